// File: rtl/cache_miss_ctrl.sv
// Cache miss controller: write-through stores and burst line refill on read misses.
// Optional RAM timeout abort (ERR state, sticky mem_err) enabled by defining MISS_TIMEOUT_EN.
module cache_miss_ctrl #(
    parameter int WORDS_PER_LINE = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        hit,
    output logic        stall,
    output logic        fill_we,
    output logic [31:0] fill_addr,
    output logic [31:0] fill_data,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic        ram_ack,
    input  logic [31:0] ram_rdata,
    output logic        mem_err
);

    localparam int CW  = $clog2(WORDS_PER_LINE);
    localparam int OFF = CW + 2;

    typedef enum logic [2:0] {IDLE, WRITE, REFILL, DONE, ERR} state_t;

    state_t          state_q, state_d;
    logic [29:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     refill_addr;
    logic            to_hit;

    // Byte offset bits never matter; keep them visibly consumed.
    logic unused_cfg;
    assign unused_cfg = TIMEOUT_CYCLES[0] ^ (^cpu_addr[1:0]);

    assign refill_addr = {addr_q[29:OFF-2], cnt_q, 2'b00};

`ifdef MISS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_q, to_d;
    logic          mem_err_q, mem_err_d;

    assign to_hit  = (to_q == TW'(TIMEOUT_CYCLES - 1)) && !ram_ack;
    assign mem_err = mem_err_q;

    // Idle clears the timer, so it always starts at zero on WRITE/REFILL entry.
    always_comb begin
        to_d      = to_q;
        mem_err_d = mem_err_q | (state_d == ERR);
        if (state_q == IDLE || ram_ack)
            to_d = '0;
        else if (state_q == WRITE || state_q == REFILL)
            to_d = to_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_q      <= '0;
            mem_err_q <= 1'b0;
        end else begin
            to_q      <= to_d;
            mem_err_q <= mem_err_d;
        end
    end
`else
    assign to_hit  = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        stall     = 1'b0;
        fill_we   = 1'b0;
        fill_addr = '0;
        fill_data = '0;
        ram_req   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;

        unique case (state_q)
            IDLE: begin
                if (cpu_req && (cpu_we || !hit)) begin
                    stall   = 1'b1;
                    addr_d  = cpu_addr[31:2];
                    wdata_d = cpu_wdata;
                    cnt_d   = '0;
                    state_d = cpu_we ? WRITE : REFILL;
                end
            end
            WRITE: begin
                stall     = 1'b1;
                ram_req   = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = {addr_q, 2'b00};
                ram_wdata = wdata_q;
                if (ram_ack)
                    state_d = DONE;
                else if (to_hit)
                    state_d = ERR;
            end
            REFILL: begin
                stall    = 1'b1;
                ram_req  = 1'b1;
                ram_addr = refill_addr;
                if (ram_ack) begin
                    fill_we   = 1'b1;
                    fill_addr = refill_addr;
                    fill_data = ram_rdata;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CW'(WORDS_PER_LINE - 1)) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end else if (to_hit) begin
                    state_d = ERR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                stall = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
